pc_seq_ctrl: RTL and testbench
==============================

Name: pc_seq_ctrl

Overview:
Multi-cycle sequencer that drives the program counter's control interface (enable, 2-bit next-PC select, 8-bit offset/target) and the surrounding fetch/execute strobes. Fetches an instruction over a req/valid handshake, latches it, decodes it, and issues ALU, register-file and data-memory strobes. Closes every instruction with exactly one PC-update command. Sits between instruction/data memory and the datapath, as the source of every PC change in the CPU.

Parameters:
IW, 16, instruction width (opcode [15:11], rd [10:8], imm/offset [7:0])
OPW, 5, opcode field width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  leave IDLE and begin fetching
imem_data  in  16  instruction word from instruction memory
imem_valid  in  1  imem_data valid; sampled only in FETCH
dmem_valid  in  1  data access complete; sampled only in MEM
zero_flag  in  1  registered ALU zero flag
carry_flag  in  1  registered ALU carry flag
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (STORE)
en_pc  out  1  PC update enable, one cycle per instruction
pc_ctrl  out  2  00 hold, 01 increment, 10 absolute jump, 11 PC+offset
offset_addr  out  8  ir_q[7:0]
alu_en  out  1  ALU execute strobe
alu_op  out  2  opcode[1:0]: 00 ADD, 01 SUB, 10 AND, 11 OR
rf_we  out  1  register-file write strobe
rf_waddr  out  3  ir_q[10:8]
rf_sel_mem  out  1  register write data from memory (LOAD)
halted  out  1  core halted
illegal_op  out  1  undefined opcode trapped (feature only; tied 0 otherwise)

Behaviour:
- Reset (rst=0, async): state=IDLE; ir_q=0; every output 0. A reset mid-instruction aborts the instruction immediately; an outstanding req is dropped with no PC update.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Outputs are a Moore function of state and ir_q.
- IDLE: all outputs 0. Goes to FETCH when start=1. start is ignored in every other state.
- FETCH: imem_req=1 and held until imem_valid=1. On that edge, ir_q<=imem_data and the next state is DECODE. There is no timeout.
- DECODE: one cycle, no strobes. Routing by opcode:
  - 00000 NOP, 01000 JMP, 01001 JZ, 01010 JC -> EXEC.
  - 00100-00111 ALU -> EXEC.
  - 00001 LOAD, 00010 STORE -> MEM.
  - 11111 HALT -> HALT.
  - Any other opcode is treated as NOP.
- EXEC:
  - ALU: alu_en=1, then WB.
  - NOP: en_pc=1, pc_ctrl=01, then FETCH.
  - JMP: en_pc=1, pc_ctrl=10, then FETCH.
  - JZ/JC: en_pc=1; pc_ctrl=11 if the flag sampled this cycle is 1, else 01; then FETCH.
- Jump arithmetic (performed by the PC):
  - Relative target = address of the jump instruction + zero-extended ir_q[7:0], modulo 2^16. Forward only.
  - Offset 0 re-executes the same jump, an intentional spin.
  - Absolute target = {8'h00, ir_q[7:0]}.
- MEM: dmem_req=1 and dmem_we=(opcode==STORE), held until dmem_valid=1, then WB.
- WB:
  - en_pc=1, pc_ctrl=01.
  - ALU: rf_we=1.
  - LOAD: rf_we=1 and rf_sel_mem=1.
  - STORE: rf_we=0.
  - Then FETCH.
- HALT: halted=1, en_pc=0. Left only by reset.
- Outside the single PC-update cycle, en_pc=0 and pc_ctrl=00.
- offset_addr, rf_waddr and alu_op track ir_q continuously.
- Minimum cycles per instruction, with zero-wait memory, counted from FETCH entry to the next FETCH entry:
  - NOP/jump: 3.
  - ALU: 4.
  - LOAD/STORE: 4.
- Exactly one en_pc pulse per retired instruction. HALT retires with no pulse.

Optional Feature:
Macro CTRL_TRAP_EN.
- Defined: an undefined opcode in DECODE transitions to HALT with halted=1 and illegal_op=1, both sticky until reset. No PC update occurs.
- Undefined: undefined opcodes execute as NOP and illegal_op is constant 0.

Test Plan:
- Reset then start=1; imem returns 16'h0000 with zero wait -> imem_req one cycle, then DECODE, then EXEC with en_pc=1, pc_ctrl=01; FETCH re-entered 3 cycles after the first FETCH.
- Fetch 16'h4012 (JMP, imm 8'h12) with imem_valid delayed 3 cycles -> imem_req held 4 cycles; in EXEC, en_pc=1, pc_ctrl=10, offset_addr=8'h12.
- Fetch 16'h4805 (JZ, +5): once with zero_flag=1 and once with zero_flag=0 -> pc_ctrl=11 with offset_addr=8'h05 for the first, pc_ctrl=01 for the second.
- Fetch 16'h2300 (ADD, rd=3) -> alu_en=1, alu_op=00 in EXEC; next cycle rf_we=1, rf_waddr=3, en_pc=1, pc_ctrl=01.
- Fetch 16'h0A00 (LOAD, rd=2) with dmem_valid after 2 cycles -> dmem_req=1 and dmem_we=0 for 3 cycles, then WB with rf_we=1, rf_sel_mem=1. Assert rst=0 during MEM on a repeat -> all outputs 0 immediately, state IDLE.
- Fetch 16'hF800 (HALT) -> halted=1, no en_pc pulse, start ignored. Fetch 16'hA000 (undefined): with CTRL_TRAP_EN, halted=1 and illegal_op=1; without it, NOP behaviour.

Source files
------------

// File: rtl/pc_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer and sole source of PC-update commands.
// Optional macro CTRL_TRAP_EN: undefined opcodes trap to HALT with a sticky illegal_op.
module pc_seq_ctrl #(
    parameter int IW  = 16,
    parameter int OPW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [IW-1:0] imem_data,
    input  logic          imem_valid,
    input  logic          dmem_valid,
    input  logic          zero_flag,
    input  logic          carry_flag,
    output logic          imem_req,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic          en_pc,
    output logic [1:0]    pc_ctrl,
    output logic [7:0]    offset_addr,
    output logic          alu_en,
    output logic [1:0]    alu_op,
    output logic          rf_we,
    output logic [2:0]    rf_waddr,
    output logic          rf_sel_mem,
    output logic          halted,
    output logic          illegal_op
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [OPW-1:0] OP_NOP   = 5'b00000;
    localparam logic [OPW-1:0] OP_LOAD  = 5'b00001;
    localparam logic [OPW-1:0] OP_STORE = 5'b00010;
    localparam logic [OPW-1:0] OP_JMP   = 5'b01000;
    localparam logic [OPW-1:0] OP_JZ    = 5'b01001;
    localparam logic [OPW-1:0] OP_JC    = 5'b01010;
    localparam logic [OPW-1:0] OP_HALT  = 5'b11111;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_ABS  = 2'b10;
    localparam logic [1:0] PC_REL  = 2'b11;

    state_t          state_q, state_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic [OPW-1:0]  opcode;
    logic            is_alu, is_ld, is_st, is_jmp, is_jz, is_jc, is_halt, is_undef;

    assign opcode      = ir_q[IW-1 -: OPW];
    assign offset_addr = ir_q[7:0];
    assign rf_waddr    = ir_q[10:8];
    assign alu_op      = ir_q[IW-OPW+1 : IW-OPW];

    assign is_alu   = (opcode[OPW-1:2] == 3'b001);
    assign is_ld    = (opcode == OP_LOAD);
    assign is_st    = (opcode == OP_STORE);
    assign is_jmp   = (opcode == OP_JMP);
    assign is_jz    = (opcode == OP_JZ);
    assign is_jc    = (opcode == OP_JC);
    assign is_halt  = (opcode == OP_HALT);
    assign is_undef = !(is_alu || is_ld || is_st || is_jmp || is_jz || is_jc || is_halt
                        || opcode == OP_NOP);

`ifdef CTRL_TRAP_EN
    logic ill_q, ill_d;
    assign illegal_op = ill_q;
`else
    assign illegal_op = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
`ifdef CTRL_TRAP_EN
            ill_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
`ifdef CTRL_TRAP_EN
            ill_q   <= ill_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
`ifdef CTRL_TRAP_EN
        ill_d      = ill_q;
`endif
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        en_pc      = 1'b0;
        pc_ctrl    = PC_HOLD;
        alu_en     = 1'b0;
        rf_we      = 1'b0;
        rf_sel_mem = 1'b0;
        halted     = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_d    = imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_halt)              state_d = S_HALT;
                else if (is_ld || is_st)  state_d = S_MEM;
`ifdef CTRL_TRAP_EN
                else if (is_undef) begin
                    state_d = S_HALT;
                    ill_d   = 1'b1;
                end
`endif
                else                      state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_alu) begin
                    alu_en  = 1'b1;
                    state_d = S_WB;
                end else begin
                    // Jumps and NOP-like opcodes retire here; undefined opcodes fall to increment.
                    en_pc   = 1'b1;
                    state_d = S_FETCH;
                    if (is_jmp)     pc_ctrl = PC_ABS;
                    else if (is_jz) pc_ctrl = zero_flag  ? PC_REL : PC_INC;
                    else if (is_jc) pc_ctrl = carry_flag ? PC_REL : PC_INC;
                    else            pc_ctrl = PC_INC;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_st;
                if (dmem_valid) state_d = S_WB;
            end
            S_WB: begin
                en_pc      = 1'b1;
                pc_ctrl    = PC_INC;
                rf_we      = is_alu || is_ld;
                rf_sel_mem = is_ld;
                state_d    = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: per-instruction transaction observer checked against a
// table of hand-derived expectations, hand sequences, and a rule-based random model.
module tb_pc_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, imem_valid, dmem_valid, zero_flag, carry_flag;
    logic [15:0] imem_data;
    logic        imem_req, dmem_req, dmem_we, en_pc, alu_en, rf_we, rf_sel_mem, halted, illegal_op;
    logic [1:0]  pc_ctrl, alu_op;
    logic [7:0]  offset_addr;
    logic [2:0]  rf_waddr;

    int total = 0;
    int bad   = 0;

    pc_seq_ctrl #(.IW(16), .OPW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .imem_data(imem_data),
        .imem_valid(imem_valid), .dmem_valid(dmem_valid),
        .zero_flag(zero_flag), .carry_flag(carry_flag),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .en_pc(en_pc), .pc_ctrl(pc_ctrl), .offset_addr(offset_addr),
        .alu_en(alu_en), .alu_op(alu_op), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_sel_mem(rf_sel_mem), .halted(halted), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // What one instruction looked like from FETCH entry to the next FETCH entry (or HALT).
    typedef struct {
        int cyc; int req; int en; int ctrl; int alu; int aop; int rfwe; int waddr;
        int sel; int dmreq; int dmwe; int off; int halt; int ill; int badctrl;
    } obs_t;

    typedef struct {
        logic [15:0] ins; int iw; int dw; logic zf; logic cf; obs_t exp;
    } vec_t;

    function automatic logic [23:0] all_outs();
        return {imem_req, dmem_req, dmem_we, en_pc, pc_ctrl, offset_addr, alu_en, alu_op,
                rf_we, rf_waddr, rf_sel_mem, halted, illegal_op};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    function automatic obs_t mk(logic [15:0] ins, int iw, int cyc, int en, int ctrl, int alu,
                                int rfwe, int sel, int dmreq, int dmwe, int halt, int ill);
        obs_t o;
        o.cyc = cyc; o.req = iw + 1; o.en = en; o.ctrl = ctrl; o.alu = alu;
        o.aop = int'(ins[12:11]); o.rfwe = rfwe; o.waddr = int'(ins[10:8]); o.sel = sel;
        o.dmreq = dmreq; o.dmwe = dmwe; o.off = int'(ins[7:0]); o.halt = halt; o.ill = ill;
        o.badctrl = 0;
        return o;
    endfunction

    // Instruction-level rules: cycle cost = fetch (1+wait) + decode + per-class tail.
    function automatic obs_t ref_model(logic [15:0] ins, int iw, int dw, logic zf, logic cf);
        logic [4:0] op = ins[15:11];
        int base = iw + 2;
        if (op == 5'd31)           return mk(ins, iw, base, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        if (op[4:2] == 3'b001)     return mk(ins, iw, base + 2, 1, 1, 1, 1, 0, 0, 0, 0, 0);
        if (op == 5'd1)            return mk(ins, iw, base + dw + 2, 1, 1, 0, 1, 1, dw + 1, 0, 0, 0);
        if (op == 5'd2)            return mk(ins, iw, base + dw + 2, 1, 1, 0, 0, 0, dw + 1, dw + 1, 0, 0);
        if (op == 5'd8)            return mk(ins, iw, base + 1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        if (op == 5'd9)            return mk(ins, iw, base + 1, 1, zf ? 3 : 1, 0, 0, 0, 0, 0, 0, 0);
        if (op == 5'd10)           return mk(ins, iw, base + 1, 1, cf ? 3 : 1, 0, 0, 0, 0, 0, 0, 0);
        if (op == 5'd0)            return mk(ins, iw, base + 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
`ifdef CTRL_TRAP_EN
        return mk(ins, iw, base, 0, 0, 0, 0, 0, 0, 0, 1, 1);
`else
        return mk(ins, iw, base + 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
`endif
    endfunction

    // Entered at a negedge with the DUT in FETCH; acts as both memories.
    task automatic run_instr(input logic [15:0] ins, input int iw, input int dw,
                             input logic zf, input logic cf, output obs_t o);
        int fw = 0;
        int mw = 0;
        bit left = 0;
        o = '{default: 0};
        imem_data = ins; zero_flag = zf; carry_flag = cf;
        forever begin
            imem_valid = imem_req && (fw >= iw);
            dmem_valid = dmem_req && (mw >= dw);
            if (imem_req) begin fw++; o.req++; end
            if (dmem_req) begin mw++; o.dmreq++; if (dmem_we) o.dmwe++; end
            if (en_pc) begin o.en++; o.ctrl = int'(pc_ctrl); end
            else if (pc_ctrl != 2'b00) o.badctrl++;
            if (alu_en) o.alu++;
            if (rf_we) o.rfwe++;
            if (rf_sel_mem) o.sel++;
            if (!imem_req) begin
                o.off = int'(offset_addr); o.waddr = int'(rf_waddr); o.aop = int'(alu_op);
            end
            @(negedge clk);
            o.cyc++;
            if (!imem_req) left = 1;
            if ((left && imem_req) || halted || o.cyc >= 60) break;
        end
        o.halt = int'(halted);
        o.ill  = int'(illegal_op);
    endtask

    task automatic cmp_obs(input string t, input obs_t a, input obs_t e);
        chk({t, ".cycles"}, a.cyc, e.cyc);     chk({t, ".imem_req"}, a.req, e.req);
        chk({t, ".en_pc"}, a.en, e.en);        chk({t, ".pc_ctrl"}, a.ctrl, e.ctrl);
        chk({t, ".alu_en"}, a.alu, e.alu);     chk({t, ".alu_op"}, a.aop, e.aop);
        chk({t, ".rf_we"}, a.rfwe, e.rfwe);    chk({t, ".rf_waddr"}, a.waddr, e.waddr);
        chk({t, ".sel_mem"}, a.sel, e.sel);    chk({t, ".dmem_req"}, a.dmreq, e.dmreq);
        chk({t, ".dmem_we"}, a.dmwe, e.dmwe);  chk({t, ".offset"}, a.off, e.off);
        chk({t, ".halted"}, a.halt, e.halt);   chk({t, ".illegal"}, a.ill, e.ill);
        chk({t, ".ctrl_idle"}, a.badctrl, e.badctrl);
    endtask

    task automatic reset_start();
        rst = 1'b0; start = 1'b0; imem_valid = 1'b0; dmem_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("fetch_entry", int'(imem_req), 1);
    endtask

    vec_t vt[12];
    int   ops[20];

    initial begin
        obs_t o, e;
        rst = 1'b0; start = 1'b0; imem_valid = 1'b0; dmem_valid = 1'b0;
        zero_flag = 1'b0; carry_flag = 1'b0; imem_data = 16'h0000;

        //            ins       iw dw zf cf      ins       iw cyc en ctrl alu rfwe sel dmreq dmwe halt ill
        vt[0]  = '{16'h0000, 0, 0, 0, 0, mk(16'h0000, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0)};
        vt[1]  = '{16'h4012, 3, 0, 0, 0, mk(16'h4012, 3, 6, 1, 2, 0, 0, 0, 0, 0, 0, 0)};
        vt[2]  = '{16'h4805, 0, 0, 1, 0, mk(16'h4805, 0, 3, 1, 3, 0, 0, 0, 0, 0, 0, 0)};
        vt[3]  = '{16'h4805, 0, 0, 0, 1, mk(16'h4805, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0)};
        vt[4]  = '{16'h2300, 0, 0, 0, 0, mk(16'h2300, 0, 4, 1, 1, 1, 1, 0, 0, 0, 0, 0)};
        vt[5]  = '{16'h0A00, 0, 2, 0, 0, mk(16'h0A00, 0, 6, 1, 1, 0, 1, 1, 3, 0, 0, 0)};
        vt[6]  = '{16'h1100, 0, 0, 0, 0, mk(16'h1100, 0, 4, 1, 1, 0, 0, 0, 1, 1, 0, 0)};
        vt[7]  = '{16'h5003, 0, 0, 0, 1, mk(16'h5003, 0, 3, 1, 3, 0, 0, 0, 0, 0, 0, 0)};
        vt[8]  = '{16'h5003, 0, 0, 1, 0, mk(16'h5003, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0)};
        vt[9]  = '{16'h2D01, 1, 0, 0, 0, mk(16'h2D01, 1, 5, 1, 1, 1, 1, 0, 0, 0, 0, 0)};
`ifdef CTRL_TRAP_EN
        vt[10] = '{16'hA000, 0, 0, 0, 0, mk(16'hA000, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, 1)};
`else
        vt[10] = '{16'hA000, 0, 0, 0, 0, mk(16'hA000, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0)};
`endif
        vt[11] = '{16'hF800, 1, 0, 0, 0, mk(16'hF800, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0)};

        ops = '{0, 0, 1, 2, 4, 5, 6, 7, 8, 8, 9, 9, 10, 10, 1, 2, 5, 31, 3, 20};

        // Reset state
        @(negedge clk);
        chk("reset_outs", int'(all_outs()), 0);

        reset_start();
        foreach (vt[i]) begin
            run_instr(vt[i].ins, vt[i].iw, vt[i].dw, vt[i].zf, vt[i].cf, o);
            cmp_obs($sformatf("vec%0d", i), o, vt[i].exp);
            if (vt[i].exp.halt != 0) reset_start();
        end

        // HALT ignores start and never pulses en_pc
        run_instr(16'hF800, 0, 0, 1'b0, 1'b0, o);
        chk("halt_entered", o.halt, 1);
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("halt_sticky", int'(halted), 1);
            chk("halt_no_pc", int'(en_pc), 0);
            chk("halt_no_fetch", int'(imem_req), 0);
        end
        start = 1'b0;

        // Async reset mid-MEM of a LOAD drops the access, no PC update
        reset_start();
        imem_data = 16'h0A00; imem_valid = 1'b1; dmem_valid = 1'b0;
        @(negedge clk);
        imem_valid = 1'b0;
        @(negedge clk);
        chk("mem_req_before_rst", int'(dmem_req), 1);
        #2 rst = 1'b0;
        #1 chk("rst_mid_mem_outs", int'(all_outs()), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_after_rst", int'(all_outs()), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_fetch", int'(imem_req), 1);

        // Randomized instruction stream against the instruction-level model
        for (int n = 0; n < 300; n++) begin
            logic [15:0] ins;
            int iw, dw;
            logic zf, cf;
            ins = {5'(ops[$urandom_range(0, 19)]), 11'($urandom)};
            iw = $urandom_range(0, 3); dw = $urandom_range(0, 3);
            zf = 1'($urandom); cf = 1'($urandom);
            e = ref_model(ins, iw, dw, zf, cf);
            run_instr(ins, iw, dw, zf, cf, o);
            cmp_obs($sformatf("rnd%0d_%h", n, ins), o, e);
            if (o.halt != 0 || e.halt != 0) reset_start();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
